uart_tx_periph: RTL and testbench
=================================

# uart_tx_periph

Memory-mapped UART transmitter on the CPU data bus, next to `data_ram` in the SOPC. Decodes CPU data-bus accesses (`ce`/`we`/`addr`/`data`) in its own address window, buffers written bytes in a small FIFO, and serialises them on `txd` as 8N1 frames. Gives the CPU a character-output path and status polling without stalling the pipeline.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: 16-byte window base; bits [3:0] must be 0.
- `CLKS_PER_BIT`, default 868: clocks per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2–16.
- `clk  in  1`: system clock; all state on rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `ce  in  1`: data-bus chip enable from CPU (`ram_ce_o`).
- `we  in  1`: write enable (`ram_we_o`).
- `addr  in  32`: byte address (`ram_addr_o`).
- `data_i  in  32`: write data (`ram_data_o`).
- `data_o  out  32`: read data to CPU; top level muxes it with `data_ram` output on address hit.
- `txd  out  1`: serial output, idle high.

## Operation
- Hit: `addr[31:4] == BASE_ADDR[31:4]`. `addr[3:2]` selects the register; `addr[1:0]` is ignored.
- Offset 0x0, TXDATA: a write (`ce & we & hit`) pushes `data_i[7:0]`. Reads return 0.
- Offset 0x4, STATUS: read-only except bit 3.
  - Bit 0: busy, FSM not IDLE.
  - Bit 1: full.
  - Bit 2: empty.
  - Bit 3: overflow, sticky. Writing 1 to bit 3 clears it.
  - Bits [8+:5]: FIFO count.
  - All other bits read 0.
- Offsets 0x8 and 0xC: reserved. Writes are ignored; reads return 0.
- `data_o` is combinational. It is STATUS when `ce & ~we & hit & addr[3:2]==1`, else 0.
- FIFO full/empty use the count before the edge.
  - A write while full is dropped and sets overflow. This holds even when a pop happens on the same edge.
  - A push and a pop on the same edge leave the count unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO is non-empty, pop into an 8-bit shift register and go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: 8 bits, LSB first, each `CLKS_PER_BIT` cycles, with a 3-bit bit index. Then STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles. At the end, if FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and reloads 0 on each state or bit change.
- `txd` is driven from a register, so it is glitch-free.

## Timing
- Reset values:
  - `txd`=1.
  - FSM IDLE.
  - FIFO pointers and count 0.
  - Overflow 0; shift register 0.
  - `data_o` follows the combinational rule. An idle STATUS read gives 32'h0000_0004.
- Reset is asynchronous, so reset during any state abandons the frame. `txd` goes high immediately and FIFO contents are lost.
- Write latency: a write sampled on edge E0 makes the count 1 after E0. IDLE pops on E1 and `txd` falls after E1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles from the `txd` fall to the next START or IDLE.
- STATUS reflects register state after the most recent edge; there is no extra read latency.

## Test plan
- Reset: hold `rst`=0, release, read 0x1004 -> `data_o`=32'h0000_0004, `txd`=1.
- Single byte (`CLKS_PER_BIT`=4): write 0xA5 to 0x1000 ->
  - `txd` falls one cycle after the write edge.
  - Bits are 1,0,1,0,0,1,0,1, 4 cycles each, then a 4-cycle stop.
  - Total 40 cycles; busy=1 throughout.
- Burst overflow: write 0x41..0x4A to 0x1000 on 10 consecutive cycles ->
  - The first 9 bytes are accepted: one popped, 8 buffered.
  - The 10th write is dropped.
  - STATUS = full|overflow|busy with count 8.
  - The 9 frames go out back-to-back with no idle gap: 360 cycles.
- Overflow clear: after the burst, write 32'h8 to 0x1004 -> bit 3 reads 0; other bits are unchanged.
- Decode: write to 0x2000, and write to 0x1000 with `ce`=0 -> no FIFO change, `txd` stays 1. Read 0x1008 -> 0.
- Reset mid-frame: assert `rst` during DATA bit 3 -> `txd`=1 in the same cycle. After release, STATUS=32'h0000_0004 and no further frame is sent.

Source files
------------

// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter on the CPU data bus. Written bytes are
// buffered in a small FIFO and serialised LSB first on txd. Frames are sent
// back-to-back while the FIFO has data.
//
// Register window (16 bytes at BASE_ADDR; addr[1:0] ignored):
//   0x0 TXDATA  write pushes data_i[7:0]; reads return 0
//   0x4 STATUS  [0] busy, [1] full, [2] empty, [3] overflow (sticky, W1C),
//               [12:8] FIFO count; other bits 0
//   0x8/0xC     reserved (writes ignored, reads 0)
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   ce, we  data-bus chip enable / write enable
//   addr    byte address
//   data_i  write data
//   data_o  combinational read data (STATUS on a STATUS read hit, else 0)
//   txd     registered serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    CNT_FULL  = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- bus decode ----------------
    logic w_hit, w_wr_data, w_wr_stat, w_rd_stat;
    logic w_unused;

    assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_data = ce & we & w_hit & (addr[3:2] == 2'd0);
    assign w_wr_stat = ce & we & w_hit & (addr[3:2] == 2'd1);
    assign w_rd_stat = ce & ~we & w_hit & (addr[3:2] == 2'd1);
    assign w_unused  = ^{addr[1:0], data_i[31:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [4:0]    r_count;
    logic          r_ovf;
    logic          w_full, w_empty, w_push, w_pop;
    logic [7:0]    w_head;

    // Full/empty come from the pre-edge count, so a write while full is
    // dropped even if the transmitter pops on the same edge.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == 5'd0);
    assign w_push  = w_wr_data & ~w_full;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_i[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;   // power-of-two depth wraps
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_wr_data & w_full)
                r_ovf <= 1'b1;
            else if (w_wr_stat & data_i[3])
                r_ovf <= 1'b0;
        end
    end

    // ---------------- TX FSM ----------------
    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit_idx, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_txd, w_txd_nxt;
    logic          w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    // txd is computed one cycle ahead so the line changes exactly on the
    // state/bit boundary edge and comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_txd_nxt  = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_txd_nxt   = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        // chain straight into the next frame, no idle gap
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    // ---------------- read path ----------------
    logic [31:0] w_status;
    assign w_status = {19'd0, r_count, 4'd0, r_ovf, w_empty, w_full, (r_state != S_IDLE)};
    assign data_o   = w_rd_stat ? w_status : 32'd0;
    assign txd      = r_txd;

endmodule

// File: tb/tb_uart_tx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_periph
// Scoreboard bench for uart_tx_periph (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// The driver keeps a transaction-level model: a byte queue for the FIFO and
// the edge at which the last frame was taken (a frame occupies 10 bit times,
// the next byte is taken at max(write edge + 1, previous take + frame)).
// Accepted bytes are pushed to exp_q; a monitor decodes frames from txd and
// pops/compares independently.
// ---------------------------------------------------------------------------
module tb_uart_tx_periph;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, data_i = '0;
    logic [31:0] data_o;
    logic        txd;

    uart_tx_periph #(
        .BASE_ADDR(32'h0000_1000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
        .data_i(data_i), .data_o(data_o), .txd(txd)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int           m_t = 0;
    int           last_take = -1000;
    bit           m_ovf = 1'b0;
    byte unsigned m_fifo[$];
    byte unsigned exp_q[$];
    int           starts[$];
    int           frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, m_t);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (m_t < last_take + FRAME);
        s[1]    = (m_fifo.size() == DEPTH);
        s[2]    = (m_fifo.size() == 0);
        s[3]    = m_ovf;
        s[12:8] = 5'(m_fifo.size());
        return s;
    endfunction

    function automatic void m_clear();
        m_fifo.delete();
        exp_q.delete();
        m_ovf     = 1'b0;
        last_take = -1000;
    endfunction

    // One clock edge of the reference model, using the pre-edge FIFO size.
    function automatic void m_edge(input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
        int n;
        bit hit;
        n   = m_fifo.size();
        hit = (a[31:4] == 28'h000_0100);
        if (n > 0 && m_t >= last_take + FRAME) begin
            void'(m_fifo.pop_front());
            last_take = m_t;
        end
        if (c && w && hit && a[3:2] == 2'd0) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else begin
                m_fifo.push_back(d[7:0]);
                exp_q.push_back(d[7:0]);
            end
        end
        if (c && w && hit && a[3:2] == 2'd1 && d[3]) m_ovf = 1'b0;
    endfunction

    task automatic step(input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
        ce = c; we = w; addr = a; data_i = d;
        @(posedge clk);
        m_t++;
        if (rst) m_edge(c, w, a, d);
        #1;
        ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        v = data_o;
        ce = 1'b0; addr = '0;
    endtask

    task automatic check_status(input string name);
        logic [31:0] v;
        rd(32'h0000_1004, v);
        chk(name, v, m_status());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_fifo.size() != 0 || m_t < last_take + FRAME) && n < 2000) begin
            idle();
            check_status("drain_status");
            n++;
        end
        repeat (3) idle();
        chk("drain_exp_empty", exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    logic [FRAME-1:0] smp;
    int mcnt = 0;
    bit mact = 1'b0;
    int mcyc = 0;

    task automatic check_frame();
        bit           ok;
        byte unsigned b, e;
        ok = 1'b1;
        b  = 8'h00;
        for (int k = 0; k < 10; k++)
            for (int j = 1; j < CPB; j++)
                if (smp[k*CPB+j] !== smp[k*CPB]) ok = 1'b0;
        if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*CPB];
        chk("frame_shape", {31'd0, ok}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %h expected no frame", b);
        end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'd0, b}, {24'd0, e});
        end
        frames++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mact = 1'b0;
            mcnt = 0;
        end else if (!mact) begin
            if (txd === 1'b0) begin
                mact   = 1'b1;
                smp[0] = 1'b0;
                mcnt   = 1;
                starts.push_back(mcyc);
            end
        end else begin
            smp[mcnt] = txd;
            mcnt++;
            if (mcnt == FRAME) begin
                check_frame();
                mact = 1'b0;
            end
        end
        mcyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        int          sb, fb;

        // reset
        rst = 1'b0;
        m_clear();
        repeat (3) idle();
        rst = 1'b1;
        rd(32'h0000_1004, v);
        chk("reset_status", v, 32'h0000_0004);
        chk("reset_txd", {31'd0, txd}, 32'd1);

        // single byte
        step(1'b1, 1'b1, 32'h0000_1000, 32'h0000_00A5);
        chk("txd_before_take", {31'd0, txd}, 32'd1);
        check_status("single_after_write");
        idle();
        chk("txd_fall", {31'd0, txd}, 32'd0);
        check_status("single_busy");
        repeat (FRAME - 1) begin
            idle();
            check_status("single_busy");
        end
        idle();
        check_status("single_idle_again");
        drain();

        // burst of 10 writes: 9 accepted, 10th dropped
        sb = starts.size();
        fb = frames;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 32'h0000_1000, 32'h41 + i);
            check_status("burst_status");
        end
        rd(32'h0000_1004, v);
        chk("burst_full_ovf", v, 32'h0000_080B);
        step(1'b1, 1'b1, 32'h0000_1004, 32'h0000_0008);
        rd(32'h0000_1004, v);
        chk("ovf_cleared", v, 32'h0000_0803);
        check_status("ovf_cleared_model");
        drain();
        chk("burst_frames", frames - fb, 9);
        if (starts.size() >= sb + 9)
            for (int i = 0; i < 8; i++)
                chk("burst_gap", starts[sb+i+1] - starts[sb+i], FRAME);

        // decode
        step(1'b1, 1'b1, 32'h0000_2000, 32'h55);
        check_status("decode_off_window");
        step(1'b0, 1'b1, 32'h0000_1000, 32'h66);
        check_status("decode_ce_low");
        step(1'b1, 1'b1, 32'h0000_1008, 32'h77);
        check_status("decode_reserved");
        chk("decode_txd", {31'd0, txd}, 32'd1);
        rd(32'h0000_1008, v);  chk("read_reserved", v, 32'h0);
        rd(32'h0000_1000, v);  chk("read_txdata", v, 32'h0);
        rd(32'h0000_2004, v);  chk("read_off_window", v, 32'h0);
        rd(32'h0000_1007, v);  chk("read_low_addr_ignored", v, 32'h0000_0004);
        repeat (5) idle();
        chk("decode_no_frame", {31'd0, txd}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)
                step(1'b1, 1'b1, 32'h0000_1000 | 32'($urandom_range(0, 3)), $urandom);
            else if (r == 3)
                step(1'b1, 1'b1, 32'h0000_1004, $urandom);
            else if (r == 4)
                step(1'b1, 1'b1, 32'h0000_1010 + 32'($urandom_range(0, 15)), $urandom);
            else
                idle();
            check_status("rand_status");
        end
        drain();

        // reset in the middle of DATA bit 3 (0xF0 has bit 3 = 0)
        step(1'b1, 1'b1, 32'h0000_1000, 32'h0000_00F0);
        repeat (18) idle();
        chk("pre_reset_bit3", {31'd0, txd}, 32'd0);
        rst = 1'b0;
        m_clear();
        #1;
        chk("reset_txd_immediate", {31'd0, txd}, 32'd1);
        fb = frames;
        repeat (2) idle();
        rst = 1'b1;
        rd(32'h0000_1004, v);
        chk("post_reset_status", v, 32'h0000_0004);
        repeat (60) idle();
        chk("post_reset_txd", {31'd0, txd}, 32'd1);
        chk("post_reset_no_frame", frames - fb, 0);
        check_status("post_reset_model");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
